// File: rtl/serial_compare_ctrl_if.sv
// Handshake and operand/result bundle for serial_compare_ctrl.
interface serial_compare_ctrl_if #(
  parameter int unsigned WIDTH = 12
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             et;
  logic             gt;

  modport master (
    output start, a, b,
    input  busy, done, lt, et, gt
  );

  modport slave (
    input  start, a, b,
    output busy, done, lt, et, gt
  );
endinterface

// File: rtl/serial_compare_ctrl.sv
// Unsigned magnitude comparator that walks the operands 3 bits per cycle,
// LSB slice first, so the most significant differing slice decides the result.
module serial_compare_ctrl #(
  parameter int unsigned WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 nrst,
  serial_compare_ctrl_if.slave bus
);

  localparam int unsigned NSLICE = WIDTH / 3;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  // Cascade encoding is {cl, ce, cg}
  localparam logic [2:0] CASC_EQ = 3'b010;
  localparam logic [2:0] CASC_LT = 3'b100;
  localparam logic [2:0] CASC_GT = 3'b001;

  if (WIDTH < 3 || (WIDTH % 3) != 0) begin : g_bad_width
    $error("serial_compare_ctrl: WIDTH must be a positive multiple of 3");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           r_state, w_state_n;
  logic [IDXW-1:0]  r_idx,   w_idx_n;
  logic [WIDTH-1:0] r_a,     w_a_n;
  logic [WIDTH-1:0] r_b,     w_b_n;
  logic [2:0]       r_casc,  w_casc_n;
  logic [2:0]       r_res,   w_res_n;
  logic             r_busy;
  logic             r_done;
  logic [2:0]       w_slice_a;
  logic [2:0]       w_slice_b;
  logic [2:0]       w_step;

  assign w_slice_a = 3'(r_a >> (3 * r_idx));
  assign w_slice_b = 3'(r_b >> (3 * r_idx));

  // A strictly higher slice overrides whatever the lower slices decided
  always_comb begin
    w_step = r_casc;
    if (w_slice_a > w_slice_b) begin
      w_step = CASC_GT;
    end else if (w_slice_a < w_slice_b) begin
      w_step = CASC_LT;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_a_n     = r_a;
    w_b_n     = r_b;
    w_casc_n  = r_casc;
    w_res_n   = r_res;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_n = S_COMPARE;
          w_idx_n   = '0;
          w_a_n     = bus.a;
          w_b_n     = bus.b;
          w_casc_n  = CASC_EQ;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_COMPARE: begin
        w_casc_n = w_step;
        if (r_idx == LAST_IDX) begin
          w_res_n   = w_step;
          w_state_n = S_DONE;
        end else begin
          w_idx_n = r_idx + IDXW'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_casc  <= CASC_EQ;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_a     <= w_a_n;
      r_b     <= w_b_n;
      r_casc  <= w_casc_n;
      r_res   <= w_res_n;
      r_busy  <= (w_state_n == S_COMPARE);
      r_done  <= (w_state_n == S_DONE);
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.lt   = r_res[2];
  assign bus.et   = r_res[1];
  assign bus.gt   = r_res[0];

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl; observed vector is {busy,done,lt,et,gt}.
module tb_serial_compare_ctrl;

  localparam int unsigned WIDTH = 12;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  serial_compare_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  logic [4:0] obs;
  assign obs = {bus.busy, bus.done, bus.lt, bus.et, bus.gt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst      = 1'b0;
    bus.start = 1'b1;
    bus.a     = 12'h00F;
    bus.b     = 12'h000;
    step();
    step();
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state obs=%b exp=%b", obs, 5'b00000);
    end
    bus.start = 1'b0;
    nrst      = 1'b1;
    step();
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL reset_start_ignored obs=%b exp=%b", obs, 5'b00000);
    end
  endtask

  task automatic test_equal();
    bus.a     = 12'hABC;
    bus.b     = 12'hABC;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs !== 5'b10000) begin
        errors++;
        $display("FAIL eq_busy_e%0d obs=%b exp=%b", k, obs, 5'b10000);
      end
      step();
    end
    checks++;
    if (obs !== 5'b01010) begin
      errors++;
      $display("FAIL eq_done obs=%b exp=%b", obs, 5'b01010);
    end
    step();
    checks++;
    if (obs !== 5'b00010) begin
      errors++;
      $display("FAIL eq_hold obs=%b exp=%b", obs, 5'b00010);
    end
  endtask

  task automatic test_msb_dominates();
    bus.a     = 12'h800;
    bus.b     = 12'h7FF;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs !== 5'b10010) begin
        errors++;
        $display("FAIL msb_busy_e%0d obs=%b exp=%b", k, obs, 5'b10010);
      end
      step();
    end
    checks++;
    if (obs !== 5'b01001) begin
      errors++;
      $display("FAIL msb_done obs=%b exp=%b", obs, 5'b01001);
    end
    step();
    checks++;
    if (obs !== 5'b00001) begin
      errors++;
      $display("FAIL msb_hold obs=%b exp=%b", obs, 5'b00001);
    end
  endtask

  task automatic test_lsb_and_operand_change();
    bus.a     = 12'h001;
    bus.b     = 12'h002;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.a     = 12'hFFF;
    step();
    step();
    checks++;
    if (obs !== 5'b10001) begin
      errors++;
      $display("FAIL lsb_busy obs=%b exp=%b", obs, 5'b10001);
    end
    step();
    step();
    checks++;
    if (obs !== 5'b01100) begin
      errors++;
      $display("FAIL lsb_done obs=%b exp=%b", obs, 5'b01100);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    logic       exp_done;
    bus.a     = 12'd5;
    bus.b     = 12'd3;
    bus.start = 1'b1;
    step();
    checks++;
    if (obs !== 5'b10100) begin
      errors++;
      $display("FAIL b2b_e0 obs=%b exp=%b", obs, 5'b10100);
    end
    for (int k = 1; k <= 20; k++) begin
      if (k == 17) bus.start = 1'b0;
      step();
      exp_done = (k == 4) || (k == 9) || (k == 14) || (k == 19);
      exp[4]   = (k < 19) && !exp_done;
      exp[3]   = exp_done;
      exp[2:0] = (k < 4) ? 3'b100 : 3'b001;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b_e%0d obs=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_start_while_busy();
    bus.a     = 12'h123;
    bus.b     = 12'h123;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    checks++;
    if (obs !== 5'b01010) begin
      errors++;
      $display("FAIL busy_ignore_done obs=%b exp=%b", obs, 5'b01010);
    end
    step();
    checks++;
    if (obs !== 5'b00010) begin
      errors++;
      $display("FAIL busy_not_queued obs=%b exp=%b", obs, 5'b00010);
    end
  endtask

  task automatic test_reset_mid_op();
    bus.a     = 12'h001;
    bus.b     = 12'h000;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    checks++;
    if (obs !== 5'b10010) begin
      errors++;
      $display("FAIL rst_mid_busy obs=%b exp=%b", obs, 5'b10010);
    end
    nrst = 1'b0;
    step();
    checks++;
    if (obs !== 5'b00000) begin
      errors++;
      $display("FAIL rst_mid_clear obs=%b exp=%b", obs, 5'b00000);
    end
    nrst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (obs !== 5'b00000) begin
        errors++;
        $display("FAIL rst_mid_no_done_%0d obs=%b exp=%b", k, obs, 5'b00000);
      end
    end
    bus.a     = 12'h000;
    bus.b     = 12'h001;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    checks++;
    if (obs !== 5'b10000) begin
      errors++;
      $display("FAIL rst_restart_busy obs=%b exp=%b", obs, 5'b10000);
    end
    step();
    checks++;
    if (obs !== 5'b01100) begin
      errors++;
      $display("FAIL rst_restart_done obs=%b exp=%b", obs, 5'b01100);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    nrst      = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    test_reset();
    test_equal();
    test_msb_dominates();
    test_lsb_and_operand_change();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_compare_ctrl.md
SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, giving the operand width in bits; it must be a multiple of 3 and at least 3.
REQ-002 The block SHALL have the derived constant NSLICE = WIDTH/3, the number of 3-bit slices.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock, the only clock.
REQ-005 nrst  input  1  synchronous active-low reset.
REQ-006 start  input  1  request a compare; sampled only while busy=0.
REQ-007 a  input  WIDTH  operand A, unsigned.
REQ-008 b  input  WIDTH  operand B, unsigned.
REQ-009 busy  output  1  compare in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 lt  output  1  registered result: A<B.
REQ-012 et  output  1  registered result: A=B.
REQ-013 gt  output  1  registered result: A>B.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, COMPARE and DONE.
REQ-015 In IDLE or DONE, start=1 at an edge SHALL latch a and b into internal operand registers, clear the slice index to 0, set the cascade register (cl,ce,cg) to (0,1,0) and enter COMPARE.
REQ-016 In DONE, start=0 SHALL return the FSM to IDLE.
REQ-017 In COMPARE, each edge SHALL process latched slice[idx] = bits 3*idx+2..3*idx, LSB slice first.
REQ-018 For each slice, if the A slice is greater than the B slice, the cascade register SHALL become (0,0,1).
REQ-019 For each slice, if the A slice is less than the B slice, the cascade register SHALL become (1,0,0).
REQ-020 For each slice, if the A and B slices are equal, the cascade register SHALL hold its value.
REQ-021 On the edge that processes slice NSLICE-1, the block SHALL copy the final cascade value into lt/et/gt, assert done and enter DONE.
REQ-022 On every other COMPARE edge, the block SHALL increment idx by 1.
REQ-023 Latency: start sampled at edge E0 SHALL produce updated results and done=1 at edge E0+NSLICE; done SHALL be high for exactly one cycle.
REQ-024 busy SHALL be 1 exactly while the FSM is in COMPARE (cycles E0..E0+NSLICE).
REQ-025 Back-to-back: a start accepted in DONE SHALL give a throughput of one compare per NSLICE+1 cycles.
REQ-026 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-027 Changes on a/b after the accepting edge SHALL have no effect on the compare in progress.
REQ-028 lt/et/gt SHALL change only at a completion edge and SHALL hold between compares.
REQ-029 After any completion, exactly one of lt/et/gt SHALL be 1.
REQ-030 The slice index SHALL never exceed NSLICE-1; no wrap-around SHALL occur within one compare.

Reset
REQ-031 nrst=0 at an edge SHALL force state=IDLE, busy=0, done=0, lt=0, et=0, gt=0, idx=0 and cascade=(0,1,0), regardless of state.
REQ-032 Reset during COMPARE SHALL abort the operation with no done pulse and no result update.
REQ-033 The first start after reset release SHALL be accepted normally.
REQ-034 start asserted in the same cycle as nrst=0 SHALL be ignored.

Verification
REQ-035 Equal operands: a=0xABC, b=0xABC, start at E0 -> busy=1 for 4 cycles; done=1 at E4 only; lt/et/gt=0/1/0.
REQ-036 MSB dominates: a=0x800, b=0x7FF -> lower slices give lt, top slice gives gt; final lt/et/gt=0/0/1 at E4.
REQ-037 LSB only differs: a=0x001, b=0x002 -> lt/et/gt=1/0/0; a then changed to 0xFFF at E1 -> result unchanged.
REQ-038 Busy/back-to-back: start held high continuously with a=5, b=3 -> done at E4, E9, E14, ...; every result gt=1; no extra done pulses.
REQ-039 Reset mid-op: start at E0, nrst=0 at E2 -> all outputs 0, no done pulse; nrst=1 then start with a=0, b=1 -> lt=1 at 4 edges after the accepting edge.
